// File: rtl/rx_top.sv
// rx_top: UART receiver (8N1) followed by a line parser that turns lines of
// exactly eight ASCII hex digits, ended by CR or LF, into a 32-bit value.
// It accepts the same text format that the hex-dump transmitter emits.
module rx_top #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        i_top_clk,
  input  logic        i_top_rst,
  input  logic        UART_RXD,
  output logic [7:0]  o_rx_byte,
  output logic        o_rx_byte_valid,
  output logic [31:0] o_value,
  output logic        o_value_valid,
  output logic        o_parse_err,
  output logic        o_frame_err
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [7:0]  ASCII_CR  = 8'h0D;
  localparam logic [7:0]  ASCII_LF  = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rxState_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxdS;

  rxState_e    rxState_q, rxState_d;
  logic [15:0] bitTimer_q, bitTimer_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  dataShift_q, dataShift_d;
  logic [7:0]  rxByte_q, rxByte_d;
  logic        rxByteValid_q, rxByteValid_d;
  logic        frameErr_q, frameErr_d;

  logic        isHex;
  logic [3:0]  nibble;
  logic        isTerm;
  logic [3:0]  digitCnt_q, digitCnt_d;
  logic        lineBad_q, lineBad_d;
  logic [31:0] lineShift_q, lineShift_d;
  logic [31:0] value_q, value_d;
  logic        valueValid_q, valueValid_d;
  logic        parseErr_q, parseErr_d;

  // Bring the asynchronous pin into the clock domain; flops reset to the idle level.
  always_ff @(posedge i_top_clk) begin
    if (i_top_rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], UART_RXD};
    end
  end

  assign rxdS = sync_q[SYNC_STAGES-1];

  // Byte receiver state and result registers.
  always_ff @(posedge i_top_clk) begin
    if (i_top_rst) begin
      rxState_q     <= IDLE;
      bitTimer_q    <= '0;
      bitIdx_q      <= '0;
      dataShift_q   <= '0;
      rxByte_q      <= '0;
      rxByteValid_q <= 1'b0;
      frameErr_q    <= 1'b0;
    end else begin
      rxState_q     <= rxState_d;
      bitTimer_q    <= bitTimer_d;
      bitIdx_q      <= bitIdx_d;
      dataShift_q   <= dataShift_d;
      rxByte_q      <= rxByte_d;
      rxByteValid_q <= rxByteValid_d;
      frameErr_q    <= frameErr_d;
    end
  end

  // Byte receiver next state: qualify the start bit at mid-bit, then sample each bit centre.
  always_comb begin
    rxState_d     = rxState_q;
    bitTimer_d    = bitTimer_q;
    bitIdx_d      = bitIdx_q;
    dataShift_d   = dataShift_q;
    rxByte_d      = rxByte_q;
    rxByteValid_d = 1'b0;
    frameErr_d    = 1'b0;
    case (rxState_q)
      IDLE: begin
        if (!rxdS) begin
          bitTimer_d = HALF_LAST;
          rxState_d  = START;
        end
      end
      START: begin
        if (bitTimer_q == 16'd0) begin
          if (!rxdS) begin
            rxState_d  = DATA;
            bitIdx_d   = 3'd0;
            bitTimer_d = BIT_LAST;
          end else begin
            rxState_d = IDLE;
          end
        end else begin
          bitTimer_d = bitTimer_q - 16'd1;
        end
      end
      DATA: begin
        if (bitTimer_q == 16'd0) begin
          dataShift_d[bitIdx_q] = rxdS;
          bitTimer_d            = BIT_LAST;
          if (bitIdx_q == 3'd7) begin
            rxState_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          bitTimer_d = bitTimer_q - 16'd1;
        end
      end
      STOP: begin
        if (bitTimer_q == 16'd0) begin
          if (rxdS) begin
            rxByte_d      = dataShift_q;
            rxByteValid_d = 1'b1;
          end else begin
            frameErr_d = 1'b1;
          end
          rxState_d = IDLE;
        end else begin
          bitTimer_d = bitTimer_q - 16'd1;
        end
      end
      default: begin
        rxState_d = IDLE;
      end
    endcase
  end

  // Classify the received byte as a hex digit or a line terminator.
  always_comb begin
    isHex  = 1'b0;
    nibble = 4'd0;
    isTerm = (rxByte_q == ASCII_CR) || (rxByte_q == ASCII_LF);
    if (rxByte_q >= 8'h30 && rxByte_q <= 8'h39) begin
      isHex  = 1'b1;
      nibble = rxByte_q[3:0];
    end else if ((rxByte_q >= 8'h41 && rxByte_q <= 8'h46) ||
                 (rxByte_q >= 8'h61 && rxByte_q <= 8'h66)) begin
      isHex  = 1'b1;
      nibble = rxByte_q[3:0] + 4'd9;
    end
  end

  // Line parser registers.
  always_ff @(posedge i_top_clk) begin
    if (i_top_rst) begin
      digitCnt_q   <= '0;
      lineBad_q    <= 1'b0;
      lineShift_q  <= '0;
      value_q      <= '0;
      valueValid_q <= 1'b0;
      parseErr_q   <= 1'b0;
    end else begin
      digitCnt_q   <= digitCnt_d;
      lineBad_q    <= lineBad_d;
      lineShift_q  <= lineShift_d;
      value_q      <= value_d;
      valueValid_q <= valueValid_d;
      parseErr_q   <= parseErr_d;
    end
  end

  // Line parser next state: collect digits, then accept or reject the line on its terminator.
  always_comb begin
    digitCnt_d   = digitCnt_q;
    lineBad_d    = lineBad_q;
    lineShift_d  = lineShift_q;
    value_d      = value_q;
    valueValid_d = 1'b0;
    parseErr_d   = 1'b0;
    if (frameErr_q) begin
      lineBad_d = 1'b1;
    end else if (rxByteValid_q) begin
      if (isTerm) begin
        if (digitCnt_q == 4'd8 && !lineBad_q) begin
          value_d      = lineShift_q;
          valueValid_d = 1'b1;
        end else if (digitCnt_q != 4'd0 || lineBad_q) begin
          parseErr_d = 1'b1;
        end
        digitCnt_d  = 4'd0;
        lineBad_d   = 1'b0;
        lineShift_d = 32'd0;
      end else if (isHex) begin
        lineShift_d = {lineShift_q[27:0], nibble};
        if (digitCnt_q != 4'd9) begin
          digitCnt_d = digitCnt_q + 4'd1;
        end
      end else begin
        lineBad_d = 1'b1;
      end
    end
  end

  assign o_rx_byte       = rxByte_q;
  assign o_rx_byte_valid = rxByteValid_q;
  assign o_frame_err     = frameErr_q;
  assign o_value         = value_q;
  assign o_value_valid   = valueValid_q;
  assign o_parse_err     = parseErr_q;

endmodule

// File: tb/tb_rx_top.sv
// tb_rx_top: drives serial frames into rx_top and compares its outputs with a
// line-level reference model kept in this bench.
module tb_rx_top;

  localparam int CLKS = 16;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [7:0]  rxByte;
  logic        rxByteValid;
  logic [31:0] value;
  logic        valueValid;
  logic        parseErr;
  logic        frameErr;

  int checks = 0;
  int errors = 0;

  bit [7:0] expBytes[$];
  int obsByteCnt = 0;
  int obsValueCnt = 0;
  int obsParseCnt = 0;
  int obsFrameCnt = 0;
  bit termPrev = 1'b0;

  bit [7:0] lineQ[$];
  bit lineBad = 1'b0;
  int expByteCnt = 0;
  int expValueCnt = 0;
  int expParseCnt = 0;
  int expFrameCnt = 0;
  logic [31:0] expValue = 32'd0;

  bit [7:0] badChars[5] = '{8'h47, 8'h78, 8'h20, 8'h2D, 8'h40};

  always #5 clk = ~clk;

  rx_top #(
    .CLKS_PER_BIT(CLKS),
    .SYNC_STAGES (2)
  ) dut (
    .i_top_clk      (clk),
    .i_top_rst      (rst),
    .UART_RXD       (rxd),
    .o_rx_byte      (rxByte),
    .o_rx_byte_valid(rxByteValid),
    .o_value        (value),
    .o_value_valid  (valueValid),
    .o_parse_err    (parseErr),
    .o_frame_err    (frameErr)
  );

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Watch output pulses away from the active edge; check bytes and result latency.
  always @(negedge clk) begin
    if (valueValid) begin
      obsValueCnt++;
      checkOutput("valueLatency", {31'd0, termPrev}, 32'd1);
    end
    if (parseErr) begin
      obsParseCnt++;
      checkOutput("parseErrLatency", {31'd0, termPrev}, 32'd1);
    end
    if (frameErr) begin
      obsFrameCnt++;
    end
    if (rxByteValid) begin
      obsByteCnt++;
      if (expBytes.size() > 0) begin
        checkOutput("rxByte", {24'd0, rxByte}, {24'd0, expBytes.pop_front()});
      end
    end
    termPrev = rxByteValid && (rxByte == CR || rxByte == LF);
  end

  function automatic int hexVal(input bit [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Reference model: judge a whole line when its terminator arrives.
  task automatic modelByte(input bit [7:0] c);
    logic [31:0] v;
    bit ok;
    int h;
    if (c == CR || c == LF) begin
      if (lineQ.size() != 0 || lineBad) begin
        ok = !lineBad && (lineQ.size() == 8);
        v  = 32'd0;
        foreach (lineQ[i]) begin
          h = hexVal(lineQ[i]);
          if (h < 0) ok = 1'b0;
          else v = (v << 4) | 32'(h);
        end
        if (ok) begin
          expValue = v;
          expValueCnt++;
        end else begin
          expParseCnt++;
        end
      end
      lineQ.delete();
      lineBad = 1'b0;
    end else begin
      lineQ.push_back(c);
    end
  endtask

  task automatic sendBit(input bit b);
    rxd = b;
    repeat (CLKS) @(negedge clk);
  endtask

  // Send one 8N1 frame; a low stop bit is followed by two idle bit times.
  task automatic applyStimulus(input bit [7:0] b, input bit stopOk);
    if (stopOk) begin
      expBytes.push_back(b);
      expByteCnt++;
      modelByte(b);
    end else begin
      lineBad = 1'b1;
      expFrameCnt++;
    end
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(stopOk);
    if (!stopOk) begin
      sendBit(1'b1);
      sendBit(1'b1);
    end
  endtask

  task automatic sendString(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
  endtask

  task automatic checkTotals(input string tag);
    repeat (4) @(negedge clk);
    checkOutput({tag, "Bytes"}, 32'(obsByteCnt), 32'(expByteCnt));
    checkOutput({tag, "ValueCnt"}, 32'(obsValueCnt), 32'(expValueCnt));
    checkOutput({tag, "ParseErrCnt"}, 32'(obsParseCnt), 32'(expParseCnt));
    checkOutput({tag, "FrameErrCnt"}, 32'(obsFrameCnt), 32'(expFrameCnt));
    checkOutput({tag, "Value"}, value, expValue);
  endtask

  function automatic bit [7:0] randHex();
    int d;
    d = $urandom_range(0, 15);
    if (d < 10) return 8'(48 + d);
    if ($urandom_range(0, 1) == 1) return 8'(55 + d);
    return 8'(87 + d);
  endfunction

  initial begin
    int kind, len, badPos, ferrPos, term;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("resetRxByte", {24'd0, rxByte}, 32'd0);
    checkOutput("resetValue", value, 32'd0);
    checkOutput("resetPulses", {28'd0, rxByteValid, valueValid, parseErr, frameErr}, 32'd0);

    sendString("DEADBEEF");
    applyStimulus(LF, 1'b1);
    applyStimulus(CR, 1'b1);
    checkTotals("deadbeef");

    sendString("0000a5c3");
    applyStimulus(CR, 1'b1);
    checkTotals("lower");
    applyStimulus(LF, 1'b1);
    checkTotals("emptyLine");

    sendString("12G45678");
    applyStimulus(LF, 1'b1);
    checkTotals("badChar");
    sendString("123");
    applyStimulus(LF, 1'b1);
    checkTotals("short");
    sendString("123456789");
    applyStimulus(LF, 1'b1);
    checkTotals("long");

    applyStimulus(8'h31, 1'b0);
    sendString("2345678");
    applyStimulus(LF, 1'b1);
    checkTotals("frameErr");

    rxd = 1'b0;
    repeat (CLKS / 2 - 2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    applyStimulus(8'h41, 1'b1);
    checkTotals("glitch");
    applyStimulus(LF, 1'b1);
    checkTotals("glitchLine");

    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b0);
    rxd = 1'b1;
    repeat (CLKS / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lineQ.delete();
    lineBad = 1'b0;
    expValue = 32'd0;
    repeat (3 * CLKS) @(negedge clk);
    checkTotals("midReset");
    sendString("CAFEF00D");
    applyStimulus(LF, 1'b1);
    checkTotals("cafef00d");

    for (int n = 0; n < 25; n++) begin
      kind = $urandom_range(0, 4);
      badPos = -1;
      ferrPos = -1;
      case (kind)
        0: len = 8;
        1: len = $urandom_range(0, 7);
        2: len = $urandom_range(9, 10);
        3: begin
          len = $urandom_range(1, 9);
          badPos = $urandom_range(0, len - 1);
        end
        default: begin
          len = 8;
          ferrPos = $urandom_range(0, 7);
        end
      endcase
      for (int i = 0; i < len; i++) begin
        if (i == ferrPos) applyStimulus(randHex(), 1'b0);
        else if (i == badPos) applyStimulus(badChars[$urandom_range(0, 4)], 1'b1);
        else applyStimulus(randHex(), 1'b1);
      end
      term = $urandom_range(0, 2);
      if (term == 0) applyStimulus(LF, 1'b1);
      else applyStimulus(CR, 1'b1);
      if (term == 2) applyStimulus(LF, 1'b1);
    end
    checkTotals("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
